// File: rtl/keypad_scan.sv
// keypad_scan: row-scanning 4x3 matrix keypad reader with frame-level debounce.
// Reports each accepted press once via key_valid; ghosted multi-key frames count as no key.
module keypad_scan #(
   parameter int SCAN_DIV = 25000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] key_col,
   output logic [3:0] key_row,
   output logic [3:0] key_data,
   output logic       key_valid,
   output logic       key_held
);

   localparam int              DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB      = 4'(DEBOUNCE);

   typedef enum logic {S_IDLE = 1'b0, S_HELD = 1'b1} state_t;

   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case (row)
         2'd0:    code = 4'd1 + {2'b00, col};
         2'd1:    code = 4'd4 + {2'b00, col};
         2'd2:    code = 4'd7 + {2'b00, col};
         default: begin
            case (col)
               2'd0:    code = 4'd10;
               2'd1:    code = 4'd0;
               default: code = 4'd11;
            endcase
         end
      endcase
      return code;
   endfunction

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       row_q, row_d;
   logic [3:0]       key_row_q, key_row_d;
   logic [1:0]       acc_cnt_q, acc_cnt_d;
   logic [3:0]       acc_code_q, acc_code_d;
   logic             cand_single_q, cand_single_d;
   logic [3:0]       cand_code_q, cand_code_d;
   logic [3:0]       cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic [3:0]       key_data_q, key_data_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;

   logic             tick_s, frame_done_s, frame_single_s, match_s;
   logic [1:0]       row_keys_s, col_idx_s, acc_cnt_nx_s;
   logic [2:0]       acc_sum_s;
   logic [3:0]       acc_code_nx_s, frame_code_s;

   // Next-state logic: scan timing, frame accumulation, debounce and press FSM.
   always_comb begin
      tick_s         = (div_q == DIV_LAST);
      row_keys_s     = {1'b0, key_col[0]} + {1'b0, key_col[1]} + {1'b0, key_col[2]};
      col_idx_s      = key_col[0] ? 2'd0 : (key_col[1] ? 2'd1 : 2'd2);
      acc_sum_s      = {1'b0, acc_cnt_q} + {1'b0, row_keys_s};
      // Key count saturates at 2: anything beyond one key is simply MULTI.
      acc_cnt_nx_s   = (acc_sum_s > 3'd1) ? 2'd2 : acc_sum_s[1:0];
      acc_code_nx_s  = (row_keys_s == 2'd1) ? key_code(row_q, col_idx_s) : acc_code_q;
      frame_done_s   = tick_s && (row_q == 2'd3);
      frame_single_s = (acc_cnt_nx_s == 2'd1);
      frame_code_s   = frame_single_s ? acc_code_nx_s : 4'd0;
      match_s        = (frame_single_s == cand_single_q) && (frame_code_s == cand_code_q);

      div_d         = div_q;
      row_d         = row_q;
      acc_cnt_d     = acc_cnt_q;
      acc_code_d    = acc_code_q;
      cand_single_d = cand_single_q;
      cand_code_d   = cand_code_q;
      cnt_d         = cnt_q;
      state_d       = state_q;
      key_data_d    = key_data_q;
      key_valid_d   = 1'b0;

      if (tick_s) begin
         div_d = '0;
         row_d = row_q + 2'd1;
         if (row_q == 2'd3) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = 4'd0;
         end else begin
            acc_cnt_d  = acc_cnt_nx_s;
            acc_code_d = acc_code_nx_s;
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      if (frame_done_s) begin
         if (match_s) begin
            cnt_d = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;
         end else begin
            cand_single_d = frame_single_s;
            cand_code_d   = frame_code_s;
            cnt_d         = 4'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end

      // The FSM only acts on the frame that brings the candidate to DEBOUNCE.
      if (frame_done_s && (cnt_d == DEB)) begin
         case (state_q)
            S_IDLE: begin
               if (cand_single_d) begin
                  state_d     = S_HELD;
                  key_data_d  = cand_code_d;
                  key_valid_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_HELD: begin
               if (!cand_single_d) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_HELD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end

      key_row_d  = 4'b0001 << row_d;
      key_held_d = (state_d == S_HELD);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q         <= '0;
         row_q         <= 2'd0;
         key_row_q     <= 4'b0001;
         acc_cnt_q     <= 2'd0;
         acc_code_q    <= 4'd0;
         cand_single_q <= 1'b0;
         cand_code_q   <= 4'd0;
         cnt_q         <= 4'd0;
         state_q       <= S_IDLE;
         key_data_q    <= 4'd0;
         key_valid_q   <= 1'b0;
         key_held_q    <= 1'b0;
      end else begin
         div_q         <= div_d;
         row_q         <= row_d;
         key_row_q     <= key_row_d;
         acc_cnt_q     <= acc_cnt_d;
         acc_code_q    <= acc_code_d;
         cand_single_q <= cand_single_d;
         cand_code_q   <= cand_code_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         key_data_q    <= key_data_d;
         key_valid_q   <= key_valid_d;
         key_held_q    <= key_held_d;
      end
   end

   assign key_row   = key_row_q;
   assign key_data  = key_data_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed testbench for keypad_scan with a behavioural 4x3 key matrix
// driven from key_row; key index = row*3 + col.
module tb_keypad_scan;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 2;
   localparam int FRAME    = 4 * SCAN_DIV;

   logic        clk;
   logic        rst;
   logic [2:0]  key_col;
   logic [3:0]  key_row;
   logic [3:0]  key_data;
   logic        key_valid;
   logic        key_held;
   logic [11:0] pressed;

   int checks;
   int errors;
   int strobes;
   int s0;
   int lat;

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk      (clk),
      .rst      (rst),
      .key_col  (key_col),
      .key_row  (key_row),
      .key_data (key_data),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key matrix: a pressed key connects its row drive to its column line.
   always_comb begin
      key_col = 3'b000;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (key_row[r] && pressed[r*3+c]) key_col[c] = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) strobes++;
      end
   endtask

   task automatic sync_frame();
      logic [3:0] prev;
      bit         found;
      prev  = key_row;
      found = 1'b0;
      for (int i = 0; i < 2*FRAME; i++) begin
         step(1);
         if (prev == 4'b1000 && key_row == 4'b0001) begin
            found = 1'b1;
            break;
         end
         prev = key_row;
      end
      chk("frame_sync", found, 1);
   endtask

   task automatic wait_strobe(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         step(1);
         if (key_valid === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 4*FRAME; i++) begin
         if (key_held === 1'b0) break;
         step(1);
      end
      chk(tag, key_held, 0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      strobes = 0;
      pressed = 12'd0;
      rst     = 1'b1;
      step(3);
      chk("rst_row", key_row, 4'b0001);
      chk("rst_valid", key_valid, 0);
      chk("rst_held", key_held, 0);
      chk("rst_data", key_data, 0);
      rst = 1'b0;

      // Press '5' and hold
      sync_frame();
      pressed = 12'd1 << 4;
      s0 = strobes;
      wait_strobe(3*FRAME + 4, lat);
      chk("p5_latency_ok", (lat >= 17 && lat <= 49), 1);
      chk("p5_data", key_data, 5);
      step(1);
      chk("p5_pulse_width", key_valid, 0);
      chk("p5_held", key_held, 1);
      step(4*FRAME);
      chk("p5_strobes", strobes - s0, 1);
      chk("p5_still_held", key_held, 1);

      // Release '5': held falls after two NONE frames
      sync_frame();
      pressed = 12'd0;
      s0 = strobes;
      step(FRAME + 4);
      chk("rel5_held_mid", key_held, 1);
      step(FRAME + 2);
      chk("rel5_held", key_held, 0);
      chk("rel5_data", key_data, 5);
      chk("rel5_strobes", strobes - s0, 0);

      // Press '#'
      pressed = 12'd1 << 11;
      s0 = strobes;
      wait_strobe(3*FRAME + 4, lat);
      chk("hash_seen", (lat > 0), 1);
      chk("hash_data", key_data, 11);
      step(1);
      pressed = 12'd0;
      wait_idle("hash_release");
      chk("hash_strobes", strobes - s0, 1);

      // One-frame glitch on '7'
      sync_frame();
      pressed = 12'd1 << 6;
      s0 = strobes;
      step(FRAME);
      pressed = 12'd0;
      step(3*FRAME);
      chk("glitch7_strobes", strobes - s0, 0);
      chk("glitch7_held", key_held, 0);

      // '1' and '2' together, then release '2'
      pressed = (12'd1 << 0) | (12'd1 << 1);
      s0 = strobes;
      step(4*FRAME);
      chk("multi_strobes", strobes - s0, 0);
      chk("multi_held", key_held, 0);
      pressed = 12'd1 << 0;
      wait_strobe(3*FRAME + 4, lat);
      chk("multi_to_1_seen", (lat > 0), 1);
      chk("multi_to_1_data", key_data, 1);
      step(1);
      pressed = 12'd0;
      wait_idle("one_release");
      chk("multi_strobes_total", strobes - s0, 1);

      // Hold '9', switch straight to '3', then release and press '3'
      pressed = 12'd1 << 8;
      s0 = strobes;
      wait_strobe(3*FRAME + 4, lat);
      chk("p9_data", key_data, 9);
      sync_frame();
      pressed = 12'd1 << 2;
      step(5*FRAME);
      chk("switch_strobes", strobes - s0, 1);
      chk("switch_held", key_held, 1);
      chk("switch_data", key_data, 9);
      pressed = 12'd0;
      wait_idle("switch_release");
      pressed = 12'd1 << 2;
      wait_strobe(3*FRAME + 4, lat);
      chk("p3_data", key_data, 3);
      step(1);
      chk("p3_strobes", strobes - s0, 2);
      pressed = 12'd0;
      wait_idle("p3_release");

      // Reset mid-frame with '0' held
      sync_frame();
      pressed = 12'd1 << 10;
      s0 = strobes;
      step(FRAME + 4);
      rst = 1'b1;
      step(1);
      chk("mid_rst_row", key_row, 4'b0001);
      chk("mid_rst_valid", key_valid, 0);
      chk("mid_rst_held", key_held, 0);
      chk("mid_rst_data", key_data, 0);
      step(1);
      rst = 1'b0;
      wait_strobe(4*FRAME, lat);
      chk("p0_full_debounce", (lat >= DEBOUNCE*FRAME), 1);
      chk("p0_data", key_data, 0);
      step(1);
      chk("p0_held", key_held, 1);
      step(4*FRAME);
      chk("p0_strobes", strobes - s0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, clk cycles per row-scan tick (legal range 2 or more).
REQ-002 SHALL have parameter DEBOUNCE, default 4, consecutive identical frames required to accept a state change (legal range 1 to 15).
REQ-003 SHALL have port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_col  input  3  column sense lines of the 4x3 keypad, active-high = pressed on the driven row.
REQ-006 SHALL have port key_row  output  4  one-hot active-high row drive.
REQ-007 SHALL have port key_data  output  4  code of the last accepted key: '1'..'9' = 1..9, '0' = 0, '*' = 10, '#' = 11.
REQ-008 SHALL have port key_valid  output  1  single-cycle strobe; key_data is new and valid in that cycle.
REQ-009 SHALL have port key_held  output  1  high while a debounced key is considered pressed.

Function
REQ-010 SHALL run a tick counter 0..SCAN_DIV-1; the tick is asserted in the cycle the counter equals SCAN_DIV-1, then the counter wraps to 0.
REQ-011 SHALL drive row index r (0..3) as key_row = one-hot bit r, starting at r=0 and advancing r to (r+1) mod 4 on each tick.
REQ-012 SHALL sample key_col for the current row in the tick cycle, before the row advances, so that each row settles for SCAN_DIV cycles.
REQ-013 SHALL map a sampled key at row r, column c as follows: rows 0-2 give code 3r+c+1; row 3 gives '*'=10 (c=0), '0'=0 (c=1), '#'=11 (c=2).
REQ-014 SHALL form one frame per 4 ticks, completed at the row-3 tick, classified as NONE (zero keys), SINGLE(code) (exactly one key), or MULTI (two or more keys, in any rows).
REQ-015 SHALL treat a MULTI frame as NONE for debounce purposes; ghosted combinations never produce a key.
REQ-016 SHALL keep a candidate (classification plus code) and a frame count (4 bits, saturating at DEBOUNCE).
REQ-017 SHALL set count = 1 when a frame differs from the candidate, and replace the candidate with that frame.
REQ-018 SHALL increment the count, saturating, when a frame matches the candidate.
REQ-019 SHALL use two states: IDLE (key_held=0) and HELD (key_held=1).
REQ-020 SHALL, in IDLE, accept a candidate SINGLE(k) whose count reaches DEBOUNCE: the FSM goes to HELD, key_data <= k, and key_valid pulses for exactly 1 cycle (the cycle after the completing frame's tick).
REQ-021 SHALL, in HELD, return to IDLE when candidate NONE reaches DEBOUNCE, with no strobe and key_data unchanged.
REQ-022 SHALL, in HELD, emit no strobe if a different SINGLE(j) becomes stable; the key must be released to NONE-stable before any new key is accepted.
REQ-023 SHALL produce at most one strobe per press; a held key never auto-repeats.
REQ-024 SHALL hold key_data between strobes, including through release.
REQ-025 SHALL have press-to-strobe latency between (DEBOUNCE-1)*4*SCAN_DIV+1 and (DEBOUNCE+1)*4*SCAN_DIV+1 clocks, depending on frame phase.
REQ-026 SHALL treat a DEBOUNCE=1 configuration as accepting on the first matching frame, with no other special casing.

Reset
REQ-027 SHALL, while rst is high at a clk edge, set: tick counter 0, row index 0 (key_row=4'b0001), frame accumulator cleared, candidate NONE, count 0, FSM IDLE, key_data 0, key_valid 0, key_held 0.
REQ-028 SHALL discard any partial frame or debounce progress on rst asserted mid-operation; a key still held after reset SHALL be reported once, after a full DEBOUNCE from release of reset.

Verification (SCAN_DIV=4, DEBOUNCE=2, keypad model returns key_col from key_row)
REQ-029 SHALL cover: press '5' (row 1, col 1) and hold -> exactly one key_valid with key_data=5 within 2-3 frames (33-49 clocks); key_held=1; no further strobes while held.
REQ-030 SHALL cover: release '5' -> key_held falls after 2 NONE frames; key_data stays 5; then press '#' -> one strobe with key_data=11.
REQ-031 SHALL cover: a one-frame glitch on '7' (present for exactly 1 frame) -> no strobe and key_held stays 0.
REQ-032 SHALL cover: '1' and '2' pressed together -> classified MULTI, no strobe; releasing '2' while keeping '1' -> one strobe with key_data=1.
REQ-033 SHALL cover: hold '9' until the strobe, then switch directly to '3' without release -> no second strobe until NONE is stable, then pressing '3' -> strobe with key_data=3.
REQ-034 SHALL cover: rst pulsed mid-frame with '0' held -> outputs at reset values next cycle (key_row=0001); after release of reset, one strobe with key_data=0 and key_held=1.
